// File: rtl/rsa_decrypt.sv
// rsa_decrypt: m = C^d mod n by LSB-first square-and-multiply over bit-serial interleaved modular multipliers
module rsa_decrypt #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] m,
  output logic             valid
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, REDUCE = 3'd2, EXP = 3'd3, DONE = 3'd4;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [2:0] state;
  logic [WIDTH-1:0] dr, nr, b, r, sh, acc_s, acc_p, s_nx, p_nx;
  logic [CW-1:0] cnt, ebit;
  function automatic logic [WIDTH-1:0] mstep(input logic [WIDTH-1:0] acc, input logic a,
                                             input logic [WIDTH-1:0] mc, input logic [WIDTH-1:0] md);
    logic [WIDTH+1:0] t, nn;
    nn = {2'b00, md};
    t = {1'b0, acc, 1'b0};
    t = (t >= nn) ? t - nn : t;
    t = a ? t + {2'b00, mc} : t;
    t = (t >= nn) ? t - nn : t;
    return t[WIDTH-1:0];
  endfunction
  assign s_nx = mstep(acc_s, sh[WIDTH-1], state == EXP ? b : ONE, nr);
  assign p_nx = mstep(acc_p, sh[WIDTH-1], r, nr);
  // Sequencer: capture, reduce C mod n, then WIDTH square/multiply rounds of WIDTH+1 cycles each
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dr <= '0;
      nr <= '0;
      b <= '0;
      r <= '0;
      sh <= '0;
      acc_s <= '0;
      acc_p <= '0;
      cnt <= '0;
      ebit <= '0;
      m <= '0;
      valid <= 1'b0;
    end else if (state == IDLE || state == DONE) begin
      if (ready) begin
        state <= LOAD;
        dr <= d;
        nr <= n;
        sh <= C;
        valid <= 1'b0;
      end
    end else if (state == LOAD) begin
      r <= (nr == ONE) ? '0 : ONE;
      acc_s <= '0;
      acc_p <= '0;
      cnt <= '0;
      ebit <= '0;
      valid <= 1'b0;
      state <= REDUCE;
    end else if (state == REDUCE) begin
      acc_s <= s_nx;
      sh <= sh << 1;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) begin
        b <= s_nx;
        sh <= s_nx;
        acc_s <= '0;
        cnt <= '0;
        state <= EXP;
      end
    end else if (state == EXP) begin
      if (cnt == CW'(WIDTH)) begin
        r <= dr[0] ? acc_p : r;
        b <= acc_s;
        sh <= acc_s;
        dr <= dr >> 1;
        acc_s <= '0;
        acc_p <= '0;
        cnt <= '0;
        ebit <= ebit + CW'(1);
        if (ebit == CW'(WIDTH - 1)) begin
          m <= dr[0] ? acc_p : r;
          valid <= 1'b1;
          state <= DONE;
        end
      end else begin
        acc_s <= s_nx;
        acc_p <= p_nx;
        sh <= sh << 1;
        cnt <= cnt + CW'(1);
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_rsa_decrypt.sv
// tb_rsa_decrypt: table, random and corner-sequence checks of rsa_decrypt against a modular-power model
module tb_rsa_decrypt;
  localparam int W = 16;
  localparam int L = 1 + W + W * (W + 1);
  typedef struct {
    logic [W-1:0] d, n, c, m;
  } vec_t;
  logic clk = 1'b0;
  logic reset, ready, valid;
  logic [W-1:0] d, n, C, m;
  int total = 0, bad = 0;
  vec_t tbl[9];
  rsa_decrypt #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .ready(ready), .d(d), .n(n), .C(C), .m(m), .valid(valid)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] e, input logic [W-1:0] mm, input logic [W-1:0] c);
    longint r, bb, md;
    md = longint'(mm);
    if (md == 1) return '0;
    r = 1;
    bb = longint'(c) % md;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * bb) % md;
      bb = (bb * bb) % md;
    end
    return W'(r);
  endfunction
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic launch(input logic [W-1:0] dd, input logic [W-1:0] nn, input logic [W-1:0] cc, input int hold);
    @(negedge clk);
    d = dd;
    n = nn;
    C = cc;
    ready = 1'b1;
    repeat (hold) @(negedge clk);
    ready = 1'b0;
  endtask
  task automatic await(input int start, output int lat);
    lat = -1;
    for (int k = start + 1; k <= L + 40; k++) begin
      @(negedge clk);
      if (valid) begin
        lat = k;
        break;
      end
    end
  endtask
  task automatic run_op(input string nm, input logic [W-1:0] dd, input logic [W-1:0] nn,
                        input logic [W-1:0] cc, input logic [W-1:0] expv);
    int lat;
    launch(dd, nn, cc, 1);
    check({nm, "_valid_drop"}, W'(valid), '0);
    await(0, lat);
    check({nm, "_latency"}, W'(lat), W'(L));
    check({nm, "_m"}, m, expv);
  endtask
  initial begin
    logic [W-1:0] dd, nn, cc, ev;
    logic ok, pv;
    int first, rises;
    tbl[0] = '{16'd3, 16'd33, 16'd4, 16'd31};
    tbl[1] = '{16'd1, 16'd33, 16'd37, 16'd4};
    tbl[2] = '{16'd0, 16'd33, 16'd5, 16'd1};
    tbl[3] = '{16'd5, 16'd1, 16'd9, 16'd0};
    tbl[4] = '{16'd7, 16'd10, 16'd0, 16'd0};
    tbl[5] = '{16'd2, 16'd100, 16'd12, 16'd44};
    tbl[6] = '{16'd10, 16'd1024, 16'd3, 16'd681};
    tbl[7] = '{16'd4, 16'hFFFF, 16'hFFFF, 16'd0};
    tbl[8] = '{16'd2, 16'hFFFF, 16'hFFFE, 16'd1};
    reset = 1'b1;
    ready = 1'b0;
    d = '0;
    n = '0;
    C = '0;
    repeat (3) @(negedge clk);
    check("reset_m", m, '0);
    check("reset_valid", W'(valid), '0);
    reset = 1'b0;
    run_op("small", 16'd3, 16'd33, 16'd4, 16'd31);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      ok = ok & valid & (m == 16'd31);
    end
    check("small_hold", W'(ok), W'(1));
    for (int i = 0; i < 9; i++) run_op($sformatf("tbl%0d", i), tbl[i].d, tbl[i].n, tbl[i].c, tbl[i].m);
    for (int i = 0; i < 40; i++) begin
      dd = W'($urandom);
      nn = W'($urandom) | W'(1);
      if (nn < 3) nn = 3;
      if (i % 8 == 7) nn = (nn < 4) ? W'(4) : (nn & ~W'(1));
      cc = W'($urandom);
      run_op($sformatf("rand%0d", i), dd, nn, cc, ref_pow(dd, nn, cc));
    end
    dd = W'($urandom);
    nn = W'($urandom) | W'(1) | W'(16'h8000);
    cc = W'($urandom);
    ev = ref_pow(dd, nn, cc);
    launch(dd, nn, cc, 3);
    first = -1;
    rises = 0;
    pv = 1'b0;
    for (int k = 3; k <= 2 * L; k++) begin
      @(negedge clk);
      if (valid && !pv) begin
        rises++;
        if (first < 0) first = k;
      end
      pv = valid;
      if (k >= 60 && k < 70) begin
        d = W'($urandom);
        n = W'($urandom);
        C = W'($urandom);
        ready = k[0];
      end else if (k == 70) ready = 1'b0;
    end
    check("busy_latency", W'(first), W'(L));
    check("busy_m", m, ev);
    check("busy_rises", W'(rises), W'(1));
    launch(16'd1234, 16'd4099, 16'd777, 1);
    repeat (150) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_m", m, '0);
    check("abort_valid", W'(valid), '0);
    reset = 1'b0;
    ok = 1'b0;
    repeat (L + 5) begin
      @(negedge clk);
      ok = ok | valid;
    end
    check("abort_no_result", W'(ok), '0);
    dd = W'($urandom);
    nn = W'($urandom) | W'(1) | W'(16'h0100);
    cc = W'($urandom);
    run_op("after_abort", dd, nn, cc, ref_pow(dd, nn, cc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
